// File: rtl/bsg_manycore_pod_reset_sequencer_if.sv
// Handshake bundle between the pod reset sequencer and its harness.
// Signal names match the original flat port list.
interface bsg_manycore_pod_reset_sequencer_if #(
  parameter int num_pods_p  = 4,
  parameter int ctr_width_p = 32
);
  logic                   tag_done_i;
  logic [num_pods_p-1:0]  pod_finish_i;
  logic [num_pods_p-1:0]  pod_reset_o;
  logic                   all_done_o;
  logic                   timeout_o;
  logic [ctr_width_p-1:0] global_ctr_o;

  modport master (
    output tag_done_i, pod_finish_i,
    input  pod_reset_o, all_done_o, timeout_o, global_ctr_o
  );

  modport slave (
    input  tag_done_i, pod_finish_i,
    output pod_reset_o, all_done_o, timeout_o, global_ctr_o
  );
endinterface

// File: rtl/bsg_manycore_pod_reset_sequencer.sv
// Multi-pod reset sequencer: settles on tag_done_i, releases pods in staggered
// order, counts run cycles, tracks sticky per-pod finish and flags done/timeout.
module bsg_manycore_pod_reset_sequencer #(
  parameter int num_pods_p      = 4,
  parameter int settle_cycles_p = 3,
  parameter int stagger_p       = 2,
  parameter int ctr_width_p     = 32,
  parameter int timeout_p       = 0
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_manycore_pod_reset_sequencer_if.slave bus
);

  localparam int SLOT_MAX = (num_pods_p - 1) * stagger_p;
  localparam int SLOT_W   = (SLOT_MAX < 1) ? 1 : $clog2(SLOT_MAX + 1);
  localparam int SETTLE_W = $clog2(settle_cycles_p + 1);
  localparam logic [ctr_width_p-1:0] CTR_LAST = ctr_width_p'(timeout_p - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_RELEASE, S_RUN, S_DONE, S_TIMEOUT
  } state_e;

  state_e                  state_q, state_d;
  logic [SETTLE_W-1:0]     settle_q, settle_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [num_pods_p-1:0]   pod_reset_q, pod_reset_d;
  logic [num_pods_p-1:0]   sticky_q, sticky_d;
  logic [ctr_width_p-1:0]  ctr_q, ctr_d;
  logic                    all_done_q, all_done_d;
  logic                    timeout_q, timeout_d;
  logic [num_pods_p-1:0]   slot_hit;
  logic [num_pods_p-1:0]   finish_seen;
  logic                    start_run;

  for (genvar k = 0; k < num_pods_p; k++) begin : g_slot
    assign slot_hit[k] = (slot_q == SLOT_W'(k * stagger_p));
  end

  // Finish only counts from pods already out of reset.
  assign finish_seen = sticky_q | (bus.pod_finish_i & ~pod_reset_q);

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    slot_d      = slot_q;
    pod_reset_d = pod_reset_q;
    sticky_d    = sticky_q;
    ctr_d       = ctr_q;
    all_done_d  = all_done_q;
    timeout_d   = timeout_q;
    start_run   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        settle_d = '0;
        if (bus.tag_done_i) begin
          if (settle_cycles_p == 1) start_run = 1'b1;
          else begin
            settle_d = SETTLE_W'(1);
            state_d  = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (!bus.tag_done_i) begin
          settle_d = '0;
          state_d  = S_IDLE;
        end else if (settle_q == SETTLE_W'(settle_cycles_p - 1)) begin
          start_run = 1'b1;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      S_RELEASE, S_RUN: begin
        if (bus.tag_done_i) begin
          sticky_d = finish_seen;
          if (&finish_seen) begin
            state_d    = S_DONE;
            all_done_d = 1'b1;
          end else if (timeout_p != 0 && ctr_q == CTR_LAST) begin
            state_d     = S_TIMEOUT;
            timeout_d   = 1'b1;
            pod_reset_d = '1;
          end else begin
            if (ctr_q != '1) ctr_d = ctr_q + ctr_width_p'(1);
            if (state_q == S_RELEASE) begin
              pod_reset_d = pod_reset_q & ~slot_hit;
              slot_d      = slot_q + SLOT_W'(1);
              if (slot_q == SLOT_W'(SLOT_MAX)) state_d = S_RUN;
            end
          end
        end
      end
      S_DONE, S_TIMEOUT: ;
      default: state_d = S_IDLE;
    endcase

    // Release edge: pod 0 (or every pod when unstaggered) leaves reset now.
    if (start_run) begin
      settle_d = '0;
      ctr_d    = '0;
      slot_d   = SLOT_W'(1);
      if (stagger_p == 0) pod_reset_d = '0;
      else                pod_reset_d[0] = 1'b0;
      state_d  = (stagger_p == 0 || num_pods_p == 1) ? S_RUN : S_RELEASE;
    end

    // Re-arm overrides every other transition once past SETTLE.
    if (!bus.tag_done_i && state_q != S_IDLE && state_q != S_SETTLE) begin
      state_d     = S_IDLE;
      settle_d    = '0;
      slot_d      = '0;
      pod_reset_d = '1;
      sticky_d    = '0;
      ctr_d       = '0;
      all_done_d  = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      slot_q      <= '0;
      pod_reset_q <= '1;
      sticky_q    <= '0;
      ctr_q       <= '0;
      all_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      slot_q      <= slot_d;
      pod_reset_q <= pod_reset_d;
      sticky_q    <= sticky_d;
      ctr_q       <= ctr_d;
      all_done_q  <= all_done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.pod_reset_o  = pod_reset_q;
  assign bus.all_done_o   = all_done_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.global_ctr_o = ctr_q;

endmodule
